serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 7: operand width in bits, legal range 1..15; also the count value loaded into the external counter.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request one addition; sampled only in IDLE.
REQ-005 Port a_in, input, WIDTH: operand A, captured on start acceptance.
REQ-006 Port b_in, input, WIDTH: operand B, captured on start acceptance.
REQ-007 Port count_in, input, 4: current value of the external down-counter.
REQ-008 Port Ld, output, 1: load strobe to the counter.
REQ-009 Port LdCountValue, output, 4: value to load, constant WIDTH.
REQ-010 Port decr, output, 1: decrement strobe to the counter.
REQ-011 Port sum_out, output, WIDTH+1: result {carry, sum}.
REQ-012 Port busy, output, 1: high in SHIFT and DONE.
REQ-013 Port done, output, 1: one-cycle pulse, sum_out valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1: Ld=1 combinationally in the same cycle; a_in/b_in captured into shift registers; carry flop cleared; sum shift register cleared; next state SHIFT.
REQ-016 Ld SHALL be asserted only in that IDLE cycle; LdCountValue SHALL always equal WIDTH.
REQ-017 Each SHIFT cycle: s = A[0]^B[0]^c; carry <= majority(A[0],B[0],c); A,B shift right one bit; s enters sum register at MSB, register shifts right (LSB first in, LSB-aligned after WIDTH shifts).
REQ-018 SHIFT with count_in != 0: decr=1; with count_in == 1, next state DONE, else stay SHIFT.
REQ-019 SHIFT with count_in == 0 (counter fault): decr=0, no shift, next state DONE; counter SHALL never be decremented through 0.
REQ-020 Ld and decr SHALL never be asserted in the same cycle.
REQ-021 DONE: sum_out <= {carry, sum register} at entry edge; done=1 for exactly this cycle; next state IDLE unconditionally.
REQ-022 Latency: start accepted at cycle 0 -> done high at cycle WIDTH+1; minimum start-to-start period WIDTH+2 cycles.
REQ-023 start in SHIFT or DONE SHALL be ignored, not queued; operands changing during SHIFT SHALL not affect the result.
REQ-024 sum_out SHALL hold its value from DONE until the next DONE.
REQ-025 Arithmetic is unsigned modulo 2^(WIDTH+1); no overflow flag.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, sum_out=0, done=0, busy=0, carry=0, shift registers=0, Ld=0, decr=0, regardless of clk.
REQ-027 Reset mid-operation SHALL abandon the addition; the counter value is not restored; the next accepted start reloads it.
REQ-028 First start SHALL be accepted in the first cycle after rst_n rises.

Verification (WIDTH=7, counter model attached)
REQ-029 a_in=7'h7F, b_in=7'h01, start one cycle -> Ld at cycle 0, decr cycles 1-7, done at cycle 8, sum_out=8'h80.
REQ-030 a_in=7'h55, b_in=7'h2A -> sum_out=8'h7F; a_in=7'h7F, b_in=7'h7F -> sum_out=8'hFE.
REQ-031 start held high continuously -> operations accepted at cycles 0, 9, 18; done at 8, 17, 26; no start during busy accepted.
REQ-032 rst_n pulsed low while count_in=3 in SHIFT -> same-cycle Ld=0, decr=0, busy=0, sum_out=8'h00; next start with 7'h01+7'h01 yields 8'h02.
REQ-033 count_in forced to 0 during SHIFT -> decr stays 0, done next cycle, FSM returns to IDLE.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that drives an external down-counter through Ld/decr strobes.
// Adds WIDTH-bit operands LSB first, one bit per SHIFT cycle, and presents {carry, sum} on DONE.
module serial_add_ctrl #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       count_in,
   output logic             Ld,
   output logic [3:0]       LdCountValue,
   output logic             decr,
   output logic [WIDTH:0]   sum_out,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             c_q, c_d, bit_s;
   logic [WIDTH:0]   sum_q, sum_d, s_ext;

   assign LdCountValue = 4'(WIDTH);
   assign sum_out      = sum_q;
   assign busy         = state_q != IDLE;
   assign done         = state_q == DONE;
   assign bit_s        = a_q[0] ^ b_q[0] ^ c_q;
   // new bit enters at the MSB; the extended vector keeps the slice legal for WIDTH=1
   assign s_ext        = {bit_s, s_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      s_d     = s_q;
      Ld      = 1'b0;
      decr    = 1'b0;
      case (state_q)
         IDLE: if (start && rst_n) begin
            Ld      = 1'b1;
            a_d     = a_in;
            b_d     = b_in;
            c_d     = 1'b0;
            s_d     = '0;
            state_d = SHIFT;
         end
         SHIFT: if (count_in != 4'd0) begin
            decr    = 1'b1;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            c_d     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
            s_d     = s_ext[WIDTH:1];
            state_d = count_in == 4'd1 ? DONE : SHIFT;
         end else begin
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      sum_d = (state_q == SHIFT && state_d == DONE) ? {c_d, s_d} : sum_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         s_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         s_q     <= s_d;
         sum_q   <= sum_d;
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl (WIDTH=7) with an attached down-counter model.
// Expected sums are queued when an operation is started and popped when done pulses.
module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, start, force0;
   logic [6:0] a_in, b_in;
   logic [3:0] count_in, cnt = 4'd0;
   logic       Ld, decr, busy, done;
   logic [3:0] LdCountValue;
   logic [7:0] sum_out;
   logic [7:0] exp_q[$];
   int         checks = 0, errors = 0;

   serial_add_ctrl #(.WIDTH(7)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .count_in(count_in), .Ld(Ld), .LdCountValue(LdCountValue), .decr(decr),
      .sum_out(sum_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // external counter: not reset, loaded by Ld, decremented by decr
   always @(posedge clk) begin
      if (Ld) cnt <= LdCountValue;
      else if (decr) cnt <= cnt - 4'd1;
   end
   assign count_in = force0 ? 4'd0 : cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [6:0] a, input logic [6:0] b);
      int k, nd;
      logic [7:0] e;
      e = 8'({1'b0, a} + {1'b0, b});
      @(negedge clk);
      a_in = a; b_in = b; start = 1'b1;
      #1 chk("ld_accept", Ld, 1);
      chk("decr_at_ld", decr, 0);
      exp_q.push_back(e);
      k = 0; nd = 0;
      while (k < 30) begin
         @(negedge clk);
         k++;
         start = 1'b1;
         a_in = 7'($urandom); b_in = 7'($urandom);
         #1;
         if (done) break;
         if (decr) nd++;
         if (Ld) chk("ld_in_shift", Ld, 0);
      end
      start = 1'b0;
      chk("done_cycle", k, 8);
      chk("decr_cycles", nd, 7);
      chk("busy_in_done", busy, 1);
      chk("sum", sum_out, exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx);
      @(negedge clk);
      #1 chk("done_pulse", done, 0);
      chk("busy_after", busy, 0);
      chk("sum_hold", sum_out, e);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; force0 = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(negedge clk);
      #1 chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_ld", Ld, 0);
      chk("rst_decr", decr, 0);
      chk("ldval", LdCountValue, 7);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_op(7'h7F, 7'h01);
      run_op(7'h55, 7'h2A);
      run_op(7'h7F, 7'h7F);
      run_op(7'h00, 7'h00);
      run_op(7'h3C, 7'h5A);
      run_op(7'($urandom), 7'($urandom));

      // start held high: accepts at 0, 9, 18 and done at 8, 17, 26
      @(negedge clk);
      a_in = 7'h12; b_in = 7'h34; start = 1'b1;
      for (int k = 0; k < 27; k++) begin
         if (k > 0) @(negedge clk);
         #1 chk("hold_ld", Ld, (k % 9) == 0);
         chk("hold_done", done, (k % 9) == 8);
         chk("hold_excl", Ld & decr, 0);
         if (Ld) exp_q.push_back(8'h46);
         if (done) chk("hold_sum", sum_out, exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx);
      end
      @(negedge clk);
      start = 1'b0;
      chk("hold_queue_empty", exp_q.size(), 0);

      // counter fault: count_in forced to 0 mid-SHIFT
      @(negedge clk);
      a_in = 7'h0F; b_in = 7'h01; start = 1'b1;
      #1 chk("flt_ld", Ld, 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1 chk("flt_decr_pre", decr, 1);
      end
      @(negedge clk);
      force0 = 1'b1;
      #1 chk("flt_decr", decr, 0);
      chk("flt_busy", busy, 1);
      chk("flt_done_early", done, 0);
      @(negedge clk);
      #1 chk("flt_done", done, 1);
      chk("flt_decr_done", decr, 0);
      @(negedge clk);
      force0 = 1'b0;
      #1 chk("flt_idle", busy, 0);
      run_op(7'h21, 7'h12);

      // reset mid-operation while count_in == 3
      @(negedge clk);
      a_in = 7'h33; b_in = 7'h44; start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 chk("mid_count", count_in, 3);
      chk("mid_busy", busy, 1);
      start = 1'b1;
      rst_n = 1'b0;
      #1 chk("arst_ld", Ld, 0);
      chk("arst_decr", decr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_sum", sum_out, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_op(7'h01, 7'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
